l_transform: RTL and testbench
==============================

# l_transform

Linear L-transform stage of the Grasshopper (GOST R 34.12-2015) encoder round datapath. It consumes the 128-bit S-box output of a round and produces L(a) = R¹⁶(a) by iterating the R step over GF(2⁸). It returns the result to key_xor together with the stage number it was tagged with. The block is iterative and valid/ready handshaked, which trades area against latency through UNROLL.

## Interface
- UNROLL, 1, R steps applied per clock; legal values 1, 2, 4, 8, 16; any other value is an elaboration error.
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  data_i and stage_num_i are valid.
- in_ready  output  1  block can accept an input.
- data_i  input  128  S-box output; byte a15 = data_i[127:120], a0 = data_i[7:0].
- stage_num_i  input  4  round tag, carried through unchanged.
- out_valid  output  1  data_o and stage_num_o are valid.
- out_ready  input  1  downstream accepts the output.
- data_o  output  128  L(data_i).
- stage_num_o  output  4  registered copy of stage_num_i.

## Operation
- Field: GF(2⁸) with polynomial x⁸+x⁷+x⁶+x+1 (0x1C3).
- R step:
  - l = 148·a15 ⊕ 32·a14 ⊕ 133·a13 ⊕ 16·a12 ⊕ 194·a11 ⊕ 192·a10 ⊕ 1·a9 ⊕ 251·a8 ⊕ 1·a7 ⊕ 192·a6 ⊕ 194·a5 ⊕ 16·a4 ⊕ 133·a3 ⊕ 32·a2 ⊕ 148·a1 ⊕ 1·a0.
  - Result = {l, a15..a1}: shift right by one byte and insert l at [127:120].
- Multiplications use constant GF multipliers only. No lookup RAM and no general multiplier.
- FSM states IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid & in_ready, load data_i into state register, latch stage_num_i, clear cnt, go RUN.
  - RUN: each cycle, state register ← R^UNROLL(state register), cnt ← cnt+1. When cnt = 16/UNROLL−1, go DONE.
  - DONE: out_valid=1, data_o = state register. On out_ready, go IDLE. With out_ready low, hold DONE, data_o and stage_num_o indefinitely.
- in_ready is low in RUN and DONE. Inputs offered then are not accepted and must be held by upstream.
- cnt is 4 bits wide. It never wraps because the terminal value is at most 15.
- Reset mid-operation: any state goes to IDLE immediately. The in-flight block is discarded and nothing is emitted.

## Timing
- Reset values: in_ready=1, out_valid=0, data_o=0, stage_num_o=0, state=IDLE, cnt=0.
- Acceptance is at clock edge E0.
- out_valid rises after edge E0+16/UNROLL: 16 cycles for UNROLL=1, 1 cycle for UNROLL=16.
- Output handshake completes at the first edge with out_valid & out_ready. out_valid is low after that edge.
- in_ready is high the cycle after the output handshake completes. The next acceptance is possible at that edge, with no same-cycle pass-through.
- Peak throughput is one block per 16/UNROLL+2 cycles.
- data_o, stage_num_o, out_valid and in_ready are driven from registers/state only. There is no combinational path from any input to any output.

## Structure
- Shared package gp_pkg holds:
  - the GF polynomial constant;
  - the 16 l-coefficients as a localparam array;
  - function gf_mul_const(byte, coeff);
  - the FSM state enum;
  - the 128-bit block width constant. key_xor and the S-box stage reuse this width constant.
- Sub-module r_step: combinational, 128-bit in, 128-bit out, one R step.
- l_transform instantiates UNROLL chained r_step copies between state register output and input.

## Test plan
1. Reset during RUN at cnt=5 → next cycle in_ready=1, out_valid=0, data_o=0; no output ever appears for that block.
2. Single R check: drive r_step alone with 00000000000000000000000000000100 → 94000000000000000000000000000001. Then feed 94000000000000000000000000000001 → a5940000000000000000000000000000.
3. Full L, UNROLL=1: accept 64a59400000000000000000000000000 with stage_num_i=3 → out_valid rises exactly 16 cycles later with data_o=d456584dd0e3e84cc3166e4b7fa2890d and stage_num_o=3.
4. Same vector with UNROLL=2, 4, 8 and 16 → identical data_o; latencies are 8, 4, 2 and 1 cycles respectively.
5. Backpressure: hold out_ready=0 for 10 cycles after out_valid → data_o is stable and in_ready stays 0. A second input held valid meanwhile is accepted only on the edge after out_ready=1 completes the output handshake.
6. Back-to-back random stream of 200 vectors against a software L model, with random in_valid/out_ready gaps → all outputs match in order, none dropped or duplicated, and each stage_num_o tag matches its input.

Source files
------------

// File: rtl/gp_pkg.sv
// gp_pkg: shared Grasshopper constants, GF(2^8) constant multiply and FSM state encoding
package gp_pkg;
  localparam int BLOCK_W = 128;
  localparam logic [8:0] GF_POLY = 9'h1C3;
  // index i holds the l-coefficient applied to byte a_i (a0 = bits [7:0])
  localparam logic [7:0] L_COEF [16] = '{
    8'd1, 8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1,
    8'd251, 8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148
  };
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  // with a constant coeff this folds into a fixed XOR network
  function automatic logic [7:0] gf_mul_const(input logic [7:0] b, input logic [7:0] coeff);
    logic [7:0] p, a;
    p = '0;
    a = b;
    for (int i = 0; i < 8; i++) begin
      p = coeff[i] ? p ^ a : p;
      a = {a[6:0], 1'b0} ^ (a[7] ? GF_POLY[7:0] : 8'h00);
    end
    return p;
  endfunction
endpackage

// File: rtl/l_transform_if.sv
// l_transform_if: input/output valid-ready handshake of the L-transform stage
// master drives in_valid/data_i/stage_num_i/out_ready; slave (l_transform) drives the rest
interface l_transform_if;
  import gp_pkg::*;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [BLOCK_W-1:0] data_i, data_o;
  logic [3:0] stage_num_i, stage_num_o;
  modport master(
    output in_valid, data_i, stage_num_i, out_ready,
    input in_ready, out_valid, data_o, stage_num_o
  );
  modport slave(
    input in_valid, data_i, stage_num_i, out_ready,
    output in_ready, out_valid, data_o, stage_num_o
  );
endinterface

// File: rtl/r_step.sv
// r_step: one combinational Grasshopper R step, q = {l(d), d[127:8]}
// d: 128-bit input block, q: 128-bit output block
module r_step
  import gp_pkg::*;
(
  input  logic [BLOCK_W-1:0] d,
  output logic [BLOCK_W-1:0] q
);
  logic [7:0] l;
  always_comb begin
    l = '0;
    for (int i = 0; i < 16; i++) l = l ^ gf_mul_const(d[8*i +: 8], L_COEF[i]);
  end
  assign q = {l, d[BLOCK_W-1:8]};
endmodule

// File: rtl/l_transform.sv
// l_transform: iterative L = R^16 stage, UNROLL R steps per clock, valid/ready handshaked
// clk/rst: clock and async active-high reset; bus: l_transform_if slave (data_i/stage_num_i in, data_o/stage_num_o out)
module l_transform #(
  parameter int UNROLL = 1
) (
  input logic clk,
  input logic rst,
  l_transform_if.slave bus
);
  import gp_pkg::*;
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN = RUN;
  localparam logic [1:0] S_DONE = DONE;
  localparam logic [3:0] LAST = 4'(16 / UNROLL - 1);
  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8 && UNROLL != 16) begin : g_bad_unroll
    $error("l_transform: UNROLL must be 1, 2, 4, 8 or 16");
  end
  logic [1:0] st;
  logic [3:0] cnt;
  logic [BLOCK_W-1:0] data_q;
  logic [3:0] tag_q;
  logic [BLOCK_W-1:0] chain [UNROLL+1];
  assign chain[0] = data_q;
  for (genvar g = 0; g < UNROLL; g++) begin : g_step
    r_step u_step (.d(chain[g]), .q(chain[g+1]));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= S_IDLE;
      cnt <= '0;
      data_q <= '0;
      tag_q <= '0;
    end else if (st == S_IDLE && bus.in_valid) begin
      st <= S_RUN;
      cnt <= '0;
      data_q <= bus.data_i;
      tag_q <= bus.stage_num_i;
    end else if (st == S_RUN) begin
      st <= cnt == LAST ? S_DONE : S_RUN;
      cnt <= cnt + 4'd1;
      data_q <= chain[UNROLL];
    end else if (st == S_DONE && bus.out_ready) begin
      st <= S_IDLE;
    end
  end
  assign bus.in_ready = st == S_IDLE;
  assign bus.out_valid = st == S_DONE;
  assign bus.data_o = data_q;
  assign bus.stage_num_o = tag_q;
endmodule

// File: tb/tb_l_transform.sv
// tb_l_transform: self-checking bench for l_transform and r_step with a scoreboarded random stream
module tb_l_transform;
  localparam logic [127:0] VEC = 128'h64a59400000000000000000000000000;
  localparam logic [127:0] VEC_L = 128'hd456584dd0e3e84cc3166e4b7fa2890d;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'(9'h1C3) << (i - 8));
    return p[7:0];
  endfunction
  function automatic logic [127:0] r_model(input logic [127:0] x);
    int cf [16] = '{148, 32, 133, 16, 194, 192, 1, 251, 1, 192, 194, 16, 133, 32, 148, 1};
    logic [7:0] l;
    l = '0;
    for (int j = 0; j < 16; j++) l = l ^ mul(x[127-8*j -: 8], 8'(cf[j]));
    return {l, x[127:8]};
  endfunction
  function automatic logic [127:0] l_model(input logic [127:0] x);
    logic [127:0] y;
    y = x;
    for (int i = 0; i < 16; i++) y = r_model(y);
    return y;
  endfunction
  logic [127:0] r_in, r_out;
  r_step u_r (.d(r_in), .q(r_out));
  l_transform_if b ();
  l_transform #(.UNROLL(1)) dut (.clk(clk), .rst(rst), .bus(b));
  for (genvar k = 0; k < 5; k++) begin : g_lat
    l_transform_if bx ();
    l_transform #(.UNROLL(1 << k)) u (.clk(clk), .rst(rst), .bus(bx));
    logic done = 0;
    initial begin
      int n;
      bx.in_valid = 0;
      bx.out_ready = 0;
      bx.data_i = '0;
      bx.stage_num_i = '0;
      wait (!rst);
      @(negedge clk);
      bx.in_valid = 1;
      bx.data_i = VEC;
      bx.stage_num_i = 4'(3 + k);
      @(posedge clk);
      #1 bx.in_valid = 0;
      n = 0;
      while (!bx.out_valid && n < 40) begin
        @(posedge clk);
        #1 n++;
      end
      chk($sformatf("latency_u%0d", 1 << k), 128'(n), 128'(16 >> k));
      chk($sformatf("data_u%0d", 1 << k), bx.data_o, VEC_L);
      chk($sformatf("tag_u%0d", 1 << k), 128'(bx.stage_num_o), 128'(3 + k));
      @(negedge clk);
      bx.out_ready = 1;
      @(posedge clk);
      #1 chk($sformatf("ov_drop_u%0d", 1 << k), 128'(bx.out_valid), '0);
      bx.out_ready = 0;
      done = 1;
    end
  end
  typedef struct packed {
    logic [127:0] d;
    logic [3:0] t;
  } exp_t;
  exp_t sb [$];
  initial begin
    int n, bad, cyc, got, sent;
    logic [127:0] a, c;
    logic acc;
    exp_t e;
    b.in_valid = 0;
    b.out_ready = 0;
    b.data_i = '0;
    b.stage_num_i = '0;
    r_in = 128'h00000000000000000000000000000100;
    #1 chk("r_step_1", r_out, 128'h94000000000000000000000000000001);
    r_in = 128'h94000000000000000000000000000001;
    #1 chk("r_step_2", r_out, 128'ha5940000000000000000000000000000);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(b.in_ready), 128'(1));
    chk("rst_out_valid", 128'(b.out_valid), '0);
    chk("rst_data_o", b.data_o, '0);
    chk("rst_stage", 128'(b.stage_num_o), '0);
    @(negedge clk);
    rst = 0;
    wait (g_lat[0].done && g_lat[1].done && g_lat[2].done && g_lat[3].done && g_lat[4].done);
    @(negedge clk);
    b.in_valid = 1;
    b.data_i = {4{$urandom}};
    b.stage_num_i = 4'd9;
    @(posedge clk);
    #1 b.in_valid = 0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    chk("midrst_in_ready", 128'(b.in_ready), 128'(1));
    chk("midrst_out_valid", 128'(b.out_valid), '0);
    chk("midrst_data_o", b.data_o, '0);
    @(negedge clk);
    rst = 0;
    bad = 0;
    repeat (25) begin
      @(negedge clk);
      if (b.out_valid) bad++;
    end
    chk("midrst_no_output", 128'(bad), '0);
    a = {4{$urandom}};
    c = {4{$urandom}};
    b.in_valid = 1;
    b.data_i = a;
    b.stage_num_i = 4'd5;
    @(posedge clk);
    #1 b.data_i = c;
    b.stage_num_i = 4'd6;
    n = 0;
    while (!b.out_valid && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    chk("bp_latency", 128'(n), 128'(16));
    bad = 0;
    repeat (10) begin
      @(posedge clk);
      #1 if (b.data_o !== l_model(a) || b.in_ready !== 1'b0 || b.out_valid !== 1'b1) bad++;
    end
    chk("bp_hold", 128'(bad), '0);
    chk("bp_tag", 128'(b.stage_num_o), 128'(5));
    @(negedge clk);
    b.out_ready = 1;
    @(posedge clk);
    #1;
    chk("bp_hs_out_valid", 128'(b.out_valid), '0);
    chk("bp_hs_in_ready", 128'(b.in_ready), 128'(1));
    b.out_ready = 0;
    @(posedge clk);
    #1 chk("bp_second_accept", 128'(b.in_ready), '0);
    b.in_valid = 0;
    n = 0;
    while (!b.out_valid && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    chk("bp_second_data", b.data_o, l_model(c));
    chk("bp_second_tag", 128'(b.stage_num_o), 128'(6));
    @(negedge clk);
    b.out_ready = 1;
    @(negedge clk);
    b.out_ready = 0;
    got = 0;
    sent = 0;
    fork
      while (sent < 200) begin
        @(negedge clk);
        if (!b.in_valid && $urandom_range(3) != 0) begin
          b.data_i = {4{$urandom}};
          b.stage_num_i = 4'($urandom);
          b.in_valid = 1;
        end
        acc = b.in_valid && b.in_ready;
        @(posedge clk);
        if (acc) begin
          sb.push_back('{l_model(b.data_i), b.stage_num_i});
          sent++;
          #1 b.in_valid = 0;
        end
      end
      begin
        cyc = 0;
        while (got < 200 && cyc < 20000) begin
          @(negedge clk);
          cyc++;
          b.out_ready = $urandom_range(2) != 0;
          if (b.out_valid && b.out_ready) begin
            if (sb.size() == 0) chk("sb_underflow", 128'(1), '0);
            else begin
              e = sb.pop_front();
              chk($sformatf("stream_data_%0d", got), b.data_o, e.d);
              chk($sformatf("stream_tag_%0d", got), 128'(b.stage_num_o), 128'(e.t));
            end
            got++;
          end
        end
      end
    join
    b.out_ready = 0;
    chk("stream_count", 128'(got), 128'(200));
    chk("stream_leftover", 128'(sb.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
